vec_mem_seq: RTL and testbench

Vector load/store memory sequencer for the CVP14 datapath. On a `vld` or `vst` decode it moves one full vector (16 elements × 16 bits) over the single-word memory bus, one element per cycle. For loads it delivers the assembled 256-bit vector to the vector register file's parallel write port. For stores it streams the parallel-read vector out to memory. It sits between the opcode decoder and the external memory bus, and is the only `vld`/`vst` master of `Addr`/`RD`/`WR`/`DataOut`.

---
 rtl/cvp14_pkg.sv | 27 ++
 rtl/vec_mem_seq.sv | 216 +++++++++++++++++++++
 tb/tb_vec_mem_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cvp14_pkg.sv
// Shared definitions for the CVP14 vector datapath.
//   - opcode constants for the vector memory instructions
//   - vector geometry (elements per vector, bits per element)
//   - state encoding for the vector load/store sequencer
package cvp14_pkg;

    localparam logic [3:0] OP_VLD = 4'b0100;
    localparam logic [3:0] OP_VST = 4'b0101;

    localparam int NELEM  = 16;
    localparam int WIDTH  = 16;
    localparam int CNT_W  = $clog2(NELEM);
    localparam int VEC_W  = NELEM * WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_LAST  = 3'd2,
        ST_STORE = 3'd3,
        ST_FIN   = 3'd4
    } vms_state_t;

    function automatic logic is_vmem_op(input logic [3:0] opcode);
        return (opcode == OP_VLD) || (opcode == OP_VST);
    endfunction

endpackage

// File: rtl/vec_mem_seq.sv
// Vector load/store memory sequencer.
// Moves one full vector (NELEM x WIDTH) over the single-word memory bus,
// one element per cycle. Loads assemble the vector and present it on the
// register-file parallel write port; stores stream the latched vector out.
//
// State table:
//   state    | meaning
//   ST_IDLE  | waiting for Start; Op/BaseAddr/VecIn latched on acceptance
//   ST_LOAD  | RD issued for element cnt; DataIn for element cnt-1 captured
//   ST_LAST  | read pipeline drain; element NELEM-1 captured
//   ST_STORE | WR issued for element cnt with its latched data
//   ST_FIN   | Done pulse (plus VecOutValid after a load)
//
// Ports:
//   Clk1        in   clock, all state on rising edge
//   Reset       in   asynchronous active-low reset
//   Start       in   request strobe, only honoured in ST_IDLE
//   Op          in   0 = load, 1 = store
//   BaseAddr    in   address of element 0
//   VecIn       in   store source vector
//   VecOut      out  load result, element i at [16i+15:16i]
//   VecOutValid out  one-cycle pulse when VecOut is complete
//   Busy        out  operation in progress (through the Done cycle)
//   Done        out  one-cycle completion pulse
//   Addr/RD/WR/DataOut  out  memory bus, all registered
//   DataIn      in   memory read data, valid the cycle after RD
module vec_mem_seq
    import cvp14_pkg::*;
(
    input  logic               Clk1,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Op,
    input  logic [WIDTH-1:0]   BaseAddr,
    input  logic [VEC_W-1:0]   VecIn,
    output logic [VEC_W-1:0]   VecOut,
    output logic               VecOutValid,
    output logic               Busy,
    output logic               Done,
    output logic [WIDTH-1:0]   Addr,
    output logic               RD,
    output logic               WR,
    output logic [WIDTH-1:0]   DataOut,
    input  logic [WIDTH-1:0]   DataIn
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NELEM - 1);

    vms_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_base;
    logic [VEC_W-1:0]   r_vec_in;
    logic [VEC_W-1:0]   r_vec_out;
    logic [WIDTH-1:0]   r_addr;
    logic               r_rd;
    logic               r_wr;
    logic [WIDTH-1:0]   r_dout;
    logic               r_busy;
    logic               r_done;
    logic               r_vov;

    vms_state_t         w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [WIDTH-1:0]   w_addr_inc;
    logic [WIDTH-1:0]   w_addr_nxt;
    logic               w_rd_nxt;
    logic               w_wr_nxt;
    logic [WIDTH-1:0]   w_dout_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_vov_nxt;
    logic               w_accept;
    logic               w_cap_en;
    logic [CNT_W-1:0]   w_cap_idx;

    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    // 16-bit wrap-around is intentional: the bus address space is modulo 2^16.
    assign w_addr_inc = r_base + WIDTH'(w_cnt_inc);

    // Bus outputs are computed one cycle early and registered so that every
    // output comes straight from a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = '0;
        w_rd_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
        w_dout_nxt  = '0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_vov_nxt   = 1'b0;
        w_accept    = 1'b0;
        w_cap_en    = 1'b0;
        w_cap_idx   = r_cnt - CNT_W'(1);

        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_accept   = 1'b1;
                    w_cnt_nxt  = '0;
                    w_busy_nxt = 1'b1;
                    w_addr_nxt = BaseAddr;
                    if (Op) begin
                        w_state_nxt = ST_STORE;
                        w_wr_nxt    = 1'b1;
                        w_dout_nxt  = VecIn[WIDTH-1:0];
                    end else begin
                        w_state_nxt = ST_LOAD;
                        w_rd_nxt    = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                w_busy_nxt = 1'b1;
                // Read data trails RD by one cycle, so the word arriving now
                // belongs to the previous address.
                w_cap_en   = (r_cnt != '0);
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = ST_LAST;
                end else begin
                    w_cnt_nxt  = w_cnt_inc;
                    w_rd_nxt   = 1'b1;
                    w_addr_nxt = w_addr_inc;
                end
            end

            ST_LAST: begin
                w_busy_nxt  = 1'b1;
                w_cap_en    = 1'b1;
                w_cap_idx   = LAST_IDX;
                w_state_nxt = ST_FIN;
                w_done_nxt  = 1'b1;
                w_vov_nxt   = 1'b1;
            end

            ST_STORE: begin
                w_busy_nxt = 1'b1;
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = ST_FIN;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt  = w_cnt_inc;
                    w_wr_nxt   = 1'b1;
                    w_addr_nxt = w_addr_inc;
                    w_dout_nxt = r_vec_in[int'(w_cnt_inc)*WIDTH +: WIDTH];
                end
            end

            ST_FIN: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_dout  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_vov   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_rd    <= w_rd_nxt;
            r_wr    <= w_wr_nxt;
            r_dout  <= w_dout_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_vov   <= w_vov_nxt;
        end
    end

    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            r_base   <= '0;
            r_vec_in <= '0;
        end else if (w_accept) begin
            r_base   <= BaseAddr;
            r_vec_in <= VecIn;
        end
    end

    // VecOut is updated element by element, so it keeps the previous load's
    // contents until the first capture of the next load.
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            r_vec_out <= '0;
        end else if (w_cap_en) begin
            r_vec_out[int'(w_cap_idx)*WIDTH +: WIDTH] <= DataIn;
        end
    end

    assign VecOut      = r_vec_out;
    assign VecOutValid = r_vov;
    assign Busy        = r_busy;
    assign Done        = r_done;
    assign Addr        = r_addr;
    assign RD          = r_rd;
    assign WR          = r_wr;
    assign DataOut     = r_dout;

endmodule

// File: tb/tb_vec_mem_seq.sv
module tb_vec_mem_seq;

    logic          Clk1 = 1'b0;
    logic          Reset;
    logic          Start;
    logic          Op;
    logic [15:0]   BaseAddr;
    logic [255:0]  VecIn;
    logic [255:0]  VecOut;
    logic          VecOutValid;
    logic          Busy;
    logic          Done;
    logic [15:0]   Addr;
    logic          RD;
    logic          WR;
    logic [15:0]   DataOut;
    logic [15:0]   DataIn = 16'hBEEF;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] mem [0:65535];

    vec_mem_seq dut (
        .Clk1        (Clk1),
        .Reset       (Reset),
        .Start       (Start),
        .Op          (Op),
        .BaseAddr    (BaseAddr),
        .VecIn       (VecIn),
        .VecOut      (VecOut),
        .VecOutValid (VecOutValid),
        .Busy        (Busy),
        .Done        (Done),
        .Addr        (Addr),
        .RD          (RD),
        .WR          (WR),
        .DataOut     (DataOut),
        .DataIn      (DataIn)
    );

    always #5 Clk1 = ~Clk1;

    // Memory returns the addressed word during the cycle after RD.
    always @(posedge Clk1) begin
        if (RD) DataIn <= mem[Addr];
        else    DataIn <= 16'hBEEF;
    end

    task automatic chk(input string tag, input int c, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    task automatic run_load(input logic [15:0] base, input logic [255:0] exp_vec,
                            input logic [255:0] prev_vec);
        logic [15:0] ea;
        logic        on;
        Start = 1'b1; Op = 1'b0; BaseAddr = base; VecIn = {16{16'h7777}};
        for (int c = 1; c <= 20; c++) begin
            @(posedge Clk1); #1;
            if (c == 1) Start = 1'b0;
            on = (c <= 16);
            ea = on ? base + 16'(c - 1) : 16'h0000;
            chk("ld_rd",   c, 256'(RD),          256'(on));
            chk("ld_wr",   c, 256'(WR),          256'(1'b0));
            chk("ld_addr", c, 256'(Addr),        256'(ea));
            chk("ld_dout", c, 256'(DataOut),     256'(16'h0000));
            chk("ld_busy", c, 256'(Busy),        256'(c <= 18));
            chk("ld_done", c, 256'(Done),        256'(c == 18));
            chk("ld_vov",  c, 256'(VecOutValid), 256'(c == 18));
            if (c <= 2)  chk("ld_hold", c, VecOut, prev_vec);
            if (c == 18) chk("ld_vec",  c, VecOut, exp_vec);
        end
    endtask

    // intrude: pulse Start with a different base/vector in cycle 5.
    // hold:    keep Start high so an identical second store follows.
    task automatic run_store(input logic [15:0] base, input logic [255:0] vec,
                             input logic intrude, input logic hold,
                             input logic [255:0] held_vec);
        int          k;
        int          last_c;
        logic [15:0] ea;
        logic [15:0] ed;
        logic        on;
        Start = 1'b1; Op = 1'b1; BaseAddr = base; VecIn = vec;
        last_c = hold ? 37 : 19;
        for (int c = 1; c <= last_c; c++) begin
            @(posedge Clk1); #1;
            if (!hold && c == 1) Start = 1'b0;
            if (hold && c == 19) Start = 1'b0;
            if (intrude && c == 5) begin
                Start = 1'b1; BaseAddr = 16'h3000; VecIn = ~vec;
            end
            if (intrude && c == 6) Start = 1'b0;
            k  = (hold && c >= 19) ? c - 18 : c;
            on = (k >= 1 && k <= 16) && !(hold && c == 18);
            ea = on ? base + 16'(k - 1) : 16'h0000;
            ed = on ? vec[(k - 1) * 16 +: 16] : 16'h0000;
            chk("st_wr",   c, 256'(WR),          256'(on));
            chk("st_rd",   c, 256'(RD),          256'(1'b0));
            chk("st_addr", c, 256'(Addr),        256'(ea));
            chk("st_dout", c, 256'(DataOut),     256'(ed));
            chk("st_busy", c, 256'(Busy),        256'((k >= 1 && k <= 17) && !(hold && c == 18)));
            chk("st_done", c, 256'(Done),        256'(k == 17));
            chk("st_vov",  c, 256'(VecOutValid), 256'(1'b0));
            chk("st_vhold", c, VecOut, held_vec);
        end
    endtask

    logic [255:0] exp_ld;
    logic [255:0] exp_wrap;
    logic [255:0] st_vec;
    logic [255:0] st_vec2;
    logic [15:0]  wa;

    initial begin
        Reset = 1'b0; Start = 1'b0; Op = 1'b0; BaseAddr = 16'h0; VecIn = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'h5A5A;
        for (int i = 0; i < 16; i++) begin
            mem[16'h0100 + i] = 16'h1000 + 16'(i);
            wa = 16'hFFF8 + 16'(i);
            mem[wa] = 16'hC000 + 16'(i);
            exp_ld[i*16 +: 16]   = 16'h1000 + 16'(i);
            exp_wrap[i*16 +: 16] = 16'hC000 + 16'(i);
            st_vec[i*16 +: 16]   = 16'hA000 + 16'(i);
            st_vec2[i*16 +: 16]  = 16'hB000 + 16'(i);
        end

        repeat (3) @(posedge Clk1);
        #1;
        chk("rst_vec",  0, VecOut, 256'(0));
        chk("rst_addr", 0, 256'(Addr), 256'(16'h0));
        chk("rst_bus",  0, 256'({RD, WR, Busy, Done, VecOutValid}), 256'(5'b0));
        chk("rst_dout", 0, 256'(DataOut), 256'(16'h0));
        @(negedge Clk1) Reset = 1'b1;
        @(posedge Clk1); #1;

        run_load(16'h0100, exp_ld, 256'(0));
        run_store(16'h2000, st_vec, 1'b0, 1'b0, exp_ld);
        run_load(16'hFFF8, exp_wrap, exp_ld);
        run_store(16'h4000, st_vec2, 1'b1, 1'b0, exp_wrap);
        run_store(16'h2000, st_vec, 1'b0, 1'b1, exp_wrap);

        // Abort a load in cycle 8.
        Start = 1'b1; Op = 1'b0; BaseAddr = 16'h0100;
        for (int c = 1; c <= 8; c++) begin
            @(posedge Clk1); #1;
            if (c == 1) Start = 1'b0;
            chk("ab_rd", c, 256'(RD), 256'(1'b1));
        end
        Reset = 1'b0;
        #1;
        chk("ab_vec",  8, VecOut, 256'(0));
        chk("ab_addr", 8, 256'(Addr), 256'(16'h0));
        chk("ab_bus",  8, 256'({RD, WR, Busy, Done, VecOutValid}), 256'(5'b0));
        chk("ab_dout", 8, 256'(DataOut), 256'(16'h0));
        for (int c = 9; c <= 11; c++) begin
            @(posedge Clk1); #1;
            chk("ab_rstbus", c, 256'({RD, Busy, Done, VecOutValid}), 256'(4'b0));
        end
        @(negedge Clk1) Reset = 1'b1;
        for (int c = 12; c <= 25; c++) begin
            @(posedge Clk1); #1;
            chk("ab_nodone", c, 256'({RD, Busy, Done, VecOutValid}), 256'(4'b0));
        end

        run_load(16'h0100, exp_ld, 256'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
